ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the haddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the hwdata/hrdata width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit words (power of 2).
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning the extra data-phase cycles per transfer (range 0..3).
REQ-005 SHALL have port hclk, input, 1 bit, the clock; all logic is on its rising edge.
REQ-006 SHALL have port hresetn, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have the following address-phase inputs:
- hsel, input, 1 bit: subordinate select.
- haddr, input, ADDR_WIDTH bits: byte address.
- htrans, input, 2 bits: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwrite, input, 1 bit: 1 = write.
- hsize, input, 3 bits: 0 byte, 1 halfword, 2 word.
- hburst, input, 3 bits: burst type; accepted but not used.
REQ-008 SHALL have the following data ports:
- hwdata, input, 32 bits: write data, valid in the data phase.
- hready, input, 1 bit: bus-wide ready.
- hrdata, output, 32 bits: read data.
- hreadyout, output, 1 bit: this subordinate's ready.
- hresp, output, 2 bits: 0 OKAY, 1 ERROR.

Function
REQ-009 SHALL accept an address phase when hsel=1, htrans[1]=1 and hready=1; it then latches haddr, hwrite and hsize for the data phase that follows.
REQ-010 SHALL treat IDLE, BUSY or hsel=0 with hready=1 as no transfer; the next cycle shows hreadyout=1 and hresp=OKAY with no memory access.
REQ-011 SHALL use an FSM with states ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1 and ST_ERR2; a valid accept enters ST_WAIT if WAIT_STATES>0, otherwise ST_DATA.
REQ-012 SHALL count down in ST_WAIT from WAIT_STATES with hreadyout=0 and hresp=OKAY, entering ST_DATA when the count reaches 1.
REQ-013 SHALL drive hreadyout=1 and hresp=OKAY in ST_DATA, completing the transfer in that cycle; a new accept in the same cycle is pipelined back-to-back.
REQ-014 SHALL, for a write, update memory at the end of ST_DATA using hwdata byte lanes selected by the latched addr[1:0] and hsize:
- byte: lane addr[1:0].
- halfword: lanes {addr[1],0} and {addr[1],1}.
- word: all four lanes.
REQ-015 SHALL, for a read, drive hrdata with the full addressed word in ST_DATA; unaddressed lanes carry memory contents, and hrdata holds its last value outside ST_DATA.
REQ-016 SHALL return the just-written value when a write data phase is immediately followed by a read of the same address.
REQ-017 SHALL flag an error when any of the following holds at accept: word index haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH, hsize>2, a halfword with haddr[0]=1, or a word with haddr[1:0]!=0.
REQ-018 SHALL respond to a flagged transfer with the two-cycle ERROR response, with no memory write and wait states skipped:
- ST_ERR1: hreadyout=0, hresp=ERROR.
- ST_ERR2: hreadyout=1, hresp=ERROR.
REQ-019 SHALL ignore any address phase presented during ST_ERR1, since hready=0 then.
REQ-020 SHALL accept a new address phase during ST_ERR2 when hready=1.
REQ-021 SHALL never accept an address phase while its own hreadyout=0.
REQ-022 SHALL not compute burst addresses; every SEQ beat uses the haddr presented.

Reset
REQ-023 SHALL force the following on hresetn=0, asynchronously: FSM to ST_IDLE, hreadyout=1, hresp=OKAY, hrdata=0, wait counter=0, latched controls=0.
REQ-024 SHALL abort any transfer in progress when reset asserts mid-transfer, discarding its write with no partial byte-lane update.
REQ-025 SHALL not reset memory contents.

Structure
REQ-026 SHALL place HTRANS, HSIZE, HBURST and HRESP encodings and the FSM state constants in shared package ahb_pkg, which the master also uses.
REQ-027 SHALL instantiate one sub-module, sp_ram_be: a single-port RAM, MEM_DEPTH x 32, with a 4-bit byte-enable write and asynchronous read.
REQ-028 SHALL keep the FSM, wait counter, error check and byte-lane decode in ahb_sram_slave.

Verification
REQ-029 SHALL cover a word write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> hrdata=0xDEADBEEF, hresp=OKAY, hreadyout=1 in each data phase.
REQ-030 SHALL cover byte lanes: write word 0 to 0x20, write byte 0xAA to 0x22, then read 0x20 -> 0x00AA0000; halfword 0x1234 to 0x20, then read -> 0x00AA1234.
REQ-031 SHALL cover wait states with WAIT_STATES=2: a NONSEQ read shows hreadyout=0 for exactly 2 cycles and then 1 with data; back-to-back pipelined INCR4 writes to 0x40..0x4C all land.
REQ-032 SHALL cover errors with MEM_DEPTH=256: access 0x400 -> ERROR with hreadyout 0 then 1, and memory unchanged; word access to 0x41 -> ERROR.
REQ-033 SHALL cover reset during ST_WAIT of a write: outputs return to reset values at once, and the target word is unchanged.
REQ-034 SHALL cover IDLE/BUSY and hsel=0 cycles between transfers: hreadyout=1, hresp=OKAY and no memory change.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and subordinate FSM states shared by master and slave.
// Changes here affect both sides of the bus.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

endpackage

// File: rtl/sp_ram_be.sv
// Single-port word RAM with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module sp_ram_be #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM subordinate: optional wait states, byte-lane writes,
// and a two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp
);

  localparam int IW = $clog2(MEM_DEPTH);

  ahb_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [IW+1:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] hrdata_q;
  logic [31:0] ram_rdata;
  logic [3:0]  be;
  logic        accept;
  logic        err;
  logic        unused_ok;

  assign unused_ok = ^{htrans[0], hburst};

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign accept = hsel & htrans[1] & hready & hreadyout;

  always_comb begin
    err = 1'b0;
    if ((haddr >> 2) >= ADDR_WIDTH'(MEM_DEPTH)) err = 1'b1;
    if (hsize > HSIZE_WORD) err = 1'b1;
    if (hsize == HSIZE_HALF && haddr[0]) err = 1'b1;
    if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      addr_d  = haddr[IW+1:0];
      write_d = hwrite;
      size_d  = hsize;
      if (err) begin
        state_d = ST_ERR1;
        cnt_d   = 2'd0;
      end else begin
        state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
        cnt_d   = 2'(WAIT_STATES);
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    if (state_q == ST_DATA && write_q) begin
      unique case (1'b1)
        size_q == HSIZE_BYTE: be = 4'b0001 << addr_q[1:0];
        size_q == HSIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
        size_q == HSIZE_WORD: be = 4'b1111;
        default:              be = 4'b0000;
      endcase
    end
  end

  // Read data is live only in a read data phase; otherwise the last value is held.
  assign hrdata = (state_q == ST_DATA && !write_q) ? ram_rdata : hrdata_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hrdata_q <= hrdata;
    end
  end

  sp_ram_be #(
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk_i   (hclk),
    .be_i    (be),
    .addr_i  (addr_q[IW+1:2]),
    .wdata_i (hwdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait and one two-wait instance
// sharing the address/data bus, each with its own select and ready loop.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel0 = 1'b0;
  logic        hsel2 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;

  logic        rdy0, rdy2;
  logic [1:0]  resp0, resp2;
  logic [31:0] rd0, rd2;

  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;

  logic        rdy;
  logic [1:0]  rsp;
  logic [31:0] rd;
  logic [31:0] bd [4];
  logic [31:0] t_rd;
  logic [1:0]  t_r0, t_r1;
  int          t_w;

  always #5 hclk = ~hclk;

  always_comb begin
    rdy = rdy0;
    rsp = resp0;
    rd  = rd0;
    if (cur == 2) begin
      rdy = rdy2;
      rsp = resp2;
      rd  = rd2;
    end
  end

  ahb_sram_slave #(
    .WAIT_STATES (0)
  ) u_d0 (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel0),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (rdy0),
    .hrdata    (rd0),
    .hreadyout (rdy0),
    .hresp     (resp0)
  );

  ahb_sram_slave #(
    .WAIT_STATES (2)
  ) u_d2 (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel2),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (rdy2),
    .hrdata    (rd2),
    .hreadyout (rdy2),
    .hresp     (resp2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy(input string tag, output int waits,
                          output logic [1:0] r0);
    waits = 0;
    @(negedge hclk);
    r0 = rsp;
    while (!rdy) begin
      waits++;
      if (waits > 16) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        break;
      end
      @(negedge hclk);
    end
  endtask

  task automatic xfer(input int sel, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic [1:0] r_first,
                      output logic [1:0] r_last, output int waits);
    cur    = sel;
    hsel0  = (sel == 0);
    hsel2  = (sel == 2);
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    hburst = HBURST_SINGLE;
    @(posedge hclk);
    #1;
    hsel0  = 1'b0;
    hsel2  = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = wd;
    wait_rdy("xfer", waits, r_first);
    rdata  = rd;
    r_last = rsp;
    @(posedge hclk);
    #1;
  endtask

  task automatic do_wr(input string tag, input int sel, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    logic [1:0] r0, r1;
    int w;
    xfer(sel, 1'b1, a, sz, wd, d, r0, r1, w);
    chk({tag, "_resp"}, 32'(r1), 32'(HRESP_OKAY));
    chk({tag, "_waits"}, 32'(w), (sel == 2) ? 32'd2 : 32'd0);
  endtask

  task automatic do_rd(input string tag, input int sel, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r0, r1;
    int w;
    xfer(sel, 1'b0, a, HSIZE_WORD, 32'h0, d, r0, r1, w);
    chk({tag, "_data"}, d, exp);
    chk({tag, "_resp"}, 32'(r1), 32'(HRESP_OKAY));
    chk({tag, "_waits"}, 32'(w), (sel == 2) ? 32'd2 : 32'd0);
  endtask

  task automatic do_err(input string tag, input int sel, input logic wr,
                        input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] d;
    logic [1:0] r0, r1;
    int w;
    xfer(sel, wr, a, sz, 32'hFFFF_FFFF, d, r0, r1, w);
    chk({tag, "_resp1"}, 32'(r0), 32'(HRESP_ERROR));
    chk({tag, "_resp2"}, 32'(r1), 32'(HRESP_ERROR));
    chk({tag, "_waits"}, 32'(w), 32'd1);
  endtask

  task automatic pipe_wr(input int sel, input logic [31:0] base,
                         output int twaits);
    int w;
    logic [1:0] r;
    cur    = sel;
    hsel0  = (sel == 0);
    hsel2  = (sel == 2);
    haddr  = base;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    hburst = HBURST_INCR4;
    @(posedge hclk);
    #1;
    twaits = 0;
    for (int i = 0; i < 4; i++) begin
      hwdata = bd[i];
      if (i < 3) begin
        haddr  = base + 32'(4 * (i + 1));
        htrans = HTRANS_SEQ;
      end else begin
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = HTRANS_IDLE;
      end
      wait_rdy("pipe", w, r);
      chk("pipe_resp", 32'(rsp), 32'(HRESP_OKAY));
      twaits += w;
      @(posedge hclk);
      #1;
    end
  endtask

  initial begin
    #1;
    chk("rst_rdy0", 32'(rdy0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'(HRESP_OKAY));
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rdy2", 32'(rdy2), 32'd1);
    chk("rst_rd2", rd2, 32'h0);
    #20;
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    do_wr("w10", 0, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
    do_rd("r10", 0, 32'h10, 32'hDEAD_BEEF);

    cur    = 0;
    hsel0  = 1'b1;
    haddr  = 32'h10;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    hwdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      htrans = (i == 0) ? HTRANS_IDLE : HTRANS_BUSY;
      if (i >= 2) begin
        hsel0  = 1'b0;
        htrans = HTRANS_NONSEQ;
      end
      @(negedge hclk);
      chk("idle_rdy", 32'(rdy0), 32'd1);
      chk("idle_resp", 32'(resp0), 32'(HRESP_OKAY));
      chk("idle_hold", rd0, 32'hDEAD_BEEF);
      @(posedge hclk);
      #1;
    end
    htrans = HTRANS_IDLE;
    do_rd("r10_idle", 0, 32'h10, 32'hDEAD_BEEF);

    hsel0  = 1'b1;
    haddr  = 32'h14;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    @(posedge hclk);
    #1;
    hwdata = 32'h600D_CAFE;
    hwrite = 1'b0;
    @(negedge hclk);
    chk("b2b_wr_rdy", 32'(rdy0), 32'd1);
    @(posedge hclk);
    #1;
    hsel0  = 1'b0;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("b2b_rd_data", rd0, 32'h600D_CAFE);
    chk("b2b_rd_rdy", 32'(rdy0), 32'd1);
    @(posedge hclk);
    #1;

    do_wr("w20", 0, 32'h20, HSIZE_WORD, 32'h0);
    do_wr("wb22", 0, 32'h22, HSIZE_BYTE, 32'h11AA_3344);
    do_rd("rb20", 0, 32'h20, 32'h00AA_0000);
    do_wr("wh20", 0, 32'h20, HSIZE_HALF, 32'h5566_1234);
    do_rd("rh20", 0, 32'h20, 32'h00AA_1234);
    do_wr("w24", 0, 32'h24, HSIZE_WORD, 32'h0);
    do_wr("wh26", 0, 32'h26, HSIZE_HALF, 32'hBEEF_7777);
    do_wr("wb25", 0, 32'h25, HSIZE_BYTE, 32'h0000_C300);
    do_rd("r24", 0, 32'h24, 32'hBEEF_C300);

    do_wr("w00", 0, 32'h0, HSIZE_WORD, 32'hCAFE_F00D);
    do_err("e400w", 0, 1'b1, 32'h400, HSIZE_WORD);
    do_rd("r00", 0, 32'h0, 32'hCAFE_F00D);
    do_err("e400r", 0, 1'b0, 32'h400, HSIZE_WORD);
    do_wr("w40", 0, 32'h40, HSIZE_WORD, 32'h4040_4040);
    do_err("e41", 0, 1'b1, 32'h41, HSIZE_WORD);
    do_rd("r40", 0, 32'h40, 32'h4040_4040);
    do_err("e21h", 0, 1'b1, 32'h21, HSIZE_HALF);
    do_err("esz3", 0, 1'b1, 32'h20, 3'd3);
    do_rd("r20_err", 0, 32'h20, 32'h00AA_1234);

    do_wr("w2_10", 2, 32'h10, HSIZE_WORD, 32'hA5A5_5A5A);
    do_rd("r2_10", 2, 32'h10, 32'hA5A5_5A5A);
    bd[0] = 32'h1111_0040;
    bd[1] = 32'h2222_0044;
    bd[2] = 32'h3333_0048;
    bd[3] = 32'h4444_004C;
    pipe_wr(2, 32'h40, t_w);
    chk("pipe_waits", 32'(t_w), 32'd8);
    do_rd("r2_40", 2, 32'h40, 32'h1111_0040);
    do_rd("r2_44", 2, 32'h44, 32'h2222_0044);
    do_rd("r2_48", 2, 32'h48, 32'h3333_0048);
    do_rd("r2_4c", 2, 32'h4C, 32'h4444_004C);
    do_err("e2_400", 2, 1'b1, 32'h400, HSIZE_WORD);

    do_wr("w2_80", 2, 32'h80, HSIZE_WORD, 32'h1111_1111);
    do_rd("r2_80", 2, 32'h80, 32'h1111_1111);
    cur    = 2;
    hsel2  = 1'b1;
    haddr  = 32'h80;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    @(posedge hclk);
    #1;
    hsel2  = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = 32'h9999_9999;
    @(negedge hclk);
    chk("rstw_wait", 32'(rdy2), 32'd0);
    hresetn = 1'b0;
    #1;
    chk("rstw_rdy", 32'(rdy2), 32'd1);
    chk("rstw_resp", 32'(resp2), 32'(HRESP_OKAY));
    chk("rstw_rd", rd2, 32'h0);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    do_rd("r2_80_rst", 2, 32'h80, 32'h1111_1111);
    do_rd("r10_rst", 0, 32'h10, 32'hDEAD_BEEF);

    xfer(0, 1'b0, 32'h14, HSIZE_WORD, 32'h0, t_rd, t_r0, t_r1, t_w);
    chk("r14_final", t_rd, 32'h600D_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
